aes128_decrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 103 ++++++++++
 rtl/aes_inv_round.sv | 41 ++++
 rtl/aes128_decrypt_iter.sv | 131 +++++++++++++
 tb/tb_aes128_decrypt_iter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and GF(2^8) helpers for the iterative
// AES-128 decryption engine.
//   - state_e      : engine FSM states
//   - NUM_ROUNDS   : AES-128 round count (10)
//   - SBOX         : forward S-box, used only by the key schedule
//   - INV_SBOX     : inverse S-box, used by the inverse round
//   - xtime, gf_mul, inv_mix_column, key_expand
package aes_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;

    localparam int NUM_ROUNDS = 10;

    // Round key NUM_ROUNDS..0, index r holds the key for round r.
    typedef logic [NUM_ROUNDS:0][127:0] rkeys_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // One column, top byte is row 0.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Combinational AES-128 key schedule producing all eleven round keys.
    function automatic rkeys_t key_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rkeys_t      rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NUM_ROUNDS; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
//   state_i    : 128-bit round input, byte 0 in [127:120], column-major
//   rkey_i     : round key added after InvSubBytes
//   skip_mix_i : 1 = last round (no InvMixColumns)
//   state_o    : round result
// Order: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         skip_mix_i,
    output logic [127:0] state_o
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        // Byte (row r, column c) sits at index r+4c; row r rotates right by r.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(r+4*c) -: 8] = state_i[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        for (int k = 0; k < 16; k++) begin
            subbed[127-8*k -: 8] = INV_SBOX[shifted[127-8*k -: 8]];
        end
        keyed = subbed ^ rkey_i;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_column(keyed[127-32*c -: 32]);
        end
        state_o = skip_mix_i ? keyed : mixed;
    end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// aes128_decrypt_iter: iterative AES-128 inverse cipher, one round per clock.
//   clock, reset        : single clock, synchronous active-high reset
//   start               : decrypt request, taken when ready=1
//   cipher_text_in      : ciphertext, byte 0 in [127:120]
//   key_in              : cipher key, same byte order
//   ready               : engine accepts start this cycle
//   busy                : LOAD/ROUND/FINAL in progress
//   done                : one-cycle completion pulse
//   plain_text_out      : result, held until the next completion
// Optional build macro AES_DEC_BACK2BACK_EN: accept a new block in the DONE
// cycle, saving one cycle per block.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] cipher_text_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] plain_text_out
);

    state_e       state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] pt_q, pt_d;
    logic [3:0]   rcnt_q, rcnt_d;

    rkeys_t       rks;
    logic [3:0]   rk_idx;
    logic [127:0] rk_sel;
    logic [127:0] round_out;
    logic         in_final;

    // Round keys are regenerated every cycle from the latched key.
    assign rks      = key_expand(key_q);
    assign in_final = (state_q == FINAL);
    assign rk_idx   = in_final ? 4'd0 : rcnt_q;
    assign rk_sel   = (rk_idx > 4'(NUM_ROUNDS)) ? '0 : rks[rk_idx];

    aes_inv_round u_round (
        .state_i    (blk_q),
        .rkey_i     (rk_sel),
        .skip_mix_i (in_final),
        .state_o    (round_out)
    );

    always_comb begin
        state_d = state_q;
        ct_d    = ct_q;
        key_d   = key_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        rcnt_d  = rcnt_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    ct_d    = cipher_text_in;
                    key_d   = key_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                blk_d   = ct_q ^ rks[NUM_ROUNDS];
                rcnt_d  = 4'(NUM_ROUNDS - 1);
                state_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                // A counter outside 1..9 can only come from corruption; abandon the block.
                if (rcnt_q >= 4'd1 && rcnt_q <= 4'(NUM_ROUNDS - 1)) begin
                    blk_d  = round_out;
                    rcnt_d = rcnt_q - 4'd1;
                    if (rcnt_q == 4'd1) state_d = FINAL;
                end else begin
                    state_d = IDLE;
                end
            end
            FINAL: begin
                busy    = 1'b1;
                pt_d    = round_out;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
`ifdef AES_DEC_BACK2BACK_EN
                ready = 1'b1;
                if (start) begin
                    ct_d    = cipher_text_in;
                    key_d   = key_in;
                    state_d = LOAD;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ct_q    <= '0;
            key_q   <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign plain_text_out = pt_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// tb_aes128_decrypt_iter: directed bench for aes128_decrypt_iter.
// Honours AES_DEC_BACK2BACK_EN for the DONE-cycle ready and the block period.
module tb_aes128_decrypt_iter;

    logic         clock;
    logic         reset;
    logic         start;
    logic [127:0] cipher_text_in;
    logic [127:0] key_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [127:0] plain_text_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

`ifdef AES_DEC_BACK2BACK_EN
    localparam int  PERIOD     = 12;
    localparam int  HELD_DONES = 5;
    localparam logic DONE_RDY  = 1'b1;
`else
    localparam int  PERIOD     = 13;
    localparam int  HELD_DONES = 4;
    localparam logic DONE_RDY  = 1'b0;
`endif

    aes128_decrypt_iter dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cipher_text_in (cipher_text_in),
        .key_in         (key_in),
        .ready          (ready),
        .busy           (busy),
        .done           (done),
        .plain_text_out (plain_text_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encryption, with its own S-box built from GF inversion + affine map.
    logic [7:0] tb_sb [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv, base;
        logic [7:0] e;
        inv = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gm(inv, base);
            base = gm(base, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] s, tmp;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {tb_sb[t[31:24]], tb_sb[t[23:16]], tb_sb[t[15:8]], tb_sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) tmp[127-8*k -: 8] = tb_sb[s[127-8*k -: 8]];
            s = tmp;
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    tmp[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+rr)%4)) -: 8];
            s = tmp;
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    {a0, a1, a2, a3} = s[127-32*c -: 32];
                    tmp[127-32*c -: 32] = {gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3,
                                           a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3,
                                           a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3),
                                           gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2)};
                end
                s = tmp;
            end
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // Called #1 after a clock edge with the engine idle. Returns at #1 after
    // the edge following the done cycle.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input bit scramble, output logic [127:0] pt);
        logic [127:0] hold;
        bit           hold_ok, ctl_ok;
        int           lat;
        check({tag, "_ready_idle"}, ready, 1'b1);
        hold = plain_text_out;
        start = 1'b1; cipher_text_in = ct; key_in = key;
        @(posedge clock); #1;
        start = 1'b0;
        if (scramble) begin
            cipher_text_in = {$urandom, $urandom, $urandom, $urandom};
            key_in         = {$urandom, $urandom, $urandom, $urandom};
        end
        lat = 0; hold_ok = 1'b1; ctl_ok = 1'b1;
        while (!done && lat < 20) begin
            if (plain_text_out !== hold) hold_ok = 1'b0;
            if (busy !== 1'b1 || ready !== 1'b0) ctl_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_latency"}, lat, 11);
        check({tag, "_pt_hold"}, hold_ok, 1'b1);
        check({tag, "_busy_ready"}, ctl_ok, 1'b1);
        check({tag, "_done_busy"}, busy, 1'b0);
        check({tag, "_done_ready"}, ready, DONE_RDY);
        pt = plain_text_out;
        @(posedge clock); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    logic [127:0] got, ref_pt, ref_key, ref_ct;
    int           cyc, prev, ndone;
    bit           ok, no_done;

    initial begin
        for (int i = 0; i < 256; i++) tb_sb[i] = calc_sbox(8'(i));
        reset = 1'b1; start = 1'b0; cipher_text_in = '0; key_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pt", plain_text_out, 128'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // FIPS-197 C.1, then App. B straight after with scrambled inputs.
        run_block("c1", C1_CT, C1_KEY, 1'b0, got);
        check("c1_pt", got, C1_PT);
        run_block("appb", B_CT, B_KEY, 1'b1, got);
        check("appb_pt", got, B_PT);

        // Reset sampled at E5 of a C.1 run.
        start = 1'b1; cipher_text_in = C1_CT; key_in = C1_KEY;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_ready", ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_pt", plain_text_out, 128'h0);
        no_done = 1'b1;
        repeat (20) begin
            @(posedge clock); #1;
            if (done) no_done = 1'b0;
        end
        check("midrst_no_done", no_done, 1'b1);
        run_block("c1_after_rst", C1_CT, C1_KEY, 1'b0, got);
        check("c1_after_rst_pt", got, C1_PT);

        // start held high: done period and status outputs.
        start = 1'b1; cipher_text_in = C1_CT; key_in = C1_KEY;
        cyc = 0; prev = -1; ndone = 0; ok = 1'b1;
        repeat (60) begin
            @(posedge clock); #1;
            cyc++;
            if (busy && ready) ok = 1'b0;
            if (done) begin
                ndone++;
                check("held_pt", plain_text_out, C1_PT);
                if (prev >= 0) check("held_period", cyc - prev, PERIOD);
                prev = cyc;
            end
        end
        start = 1'b0;
        check("held_count", ndone, HELD_DONES);
        check("held_busy_ready", ok, 1'b1);
        repeat (15) @(posedge clock);
        #1;

        // Loopback against the reference encryption.
        for (int i = 0; i < 100; i++) begin
            ref_pt  = {$urandom, $urandom, $urandom, $urandom};
            ref_key = {$urandom, $urandom, $urandom, $urandom};
            ref_ct  = model_encrypt(ref_pt, ref_key);
            run_block("loop", ref_ct, ref_key, 1'b1, got);
            check("loop_pt", got, ref_pt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
